// File: rtl/issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : issue_scoreboard
// Description : In-order issue scoreboard. It tracks pending destination
//               writes for 32 integer and 32 float registers and
//               detects RAW and WAW hazards, with a writeback bypass. It
//               also arbitrates a single iterative (fdiv/fsqrt) unit and
//               counts stall cycles. A sticky error flag records protocol
//               violations.
// Ports       : clock, reset_n            - clock, async active-low reset
//               issue_valid / issue_ready - issue handshake (ready is comb)
//               rs1..3, rs*_f, uses_rs*   - source index, file, read flag
//               rd, rd_f, writes_rd       - destination index, file, flag
//               is_long                   - instruction needs iterative unit
//               wb_valid, wb_rd, wb_rd_f  - writeback that clears pending
//               long_done / long_busy     - iterative unit completion/state
//               pending_count             - registered popcount of pending
//               stall_cycles              - saturating stall counter
//               error                     - sticky protocol-violation flag
// Revision    : 1.0 - initial release
// ============================================================================
module issue_scoreboard #(
  parameter int STALL_W = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic [4:0]         rs3,
  input  logic               rs1_f,
  input  logic               rs2_f,
  input  logic               rs3_f,
  input  logic               uses_rs1,
  input  logic               uses_rs2,
  input  logic               uses_rs3,
  input  logic [4:0]         rd,
  input  logic               rd_f,
  input  logic               writes_rd,
  input  logic               is_long,
  input  logic               wb_valid,
  input  logic [4:0]         wb_rd,
  input  logic               wb_rd_f,
  input  logic               long_done,
  output logic               long_busy,
  output logic [6:0]         pending_count,
  output logic [STALL_W-1:0] stall_cycles,
  output logic               error
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } long_state_t;

  localparam logic [STALL_W-1:0] C_STALL_MAX = '1;

  long_state_t  r_state;
  long_state_t  w_state_nxt;
  logic [63:0]  r_pending;
  logic [63:0]  w_clr_mask;
  logic [63:0]  w_set_mask;
  logic [63:0]  w_pend_eff;
  logic [63:0]  w_pend_nxt;
  logic [6:0]   r_count;
  logic [STALL_W-1:0] r_stall;
  logic         r_error;
  logic         r_armed;
  logic         w_wb_live;
  logic         w_rd_live;
  logic         w_src_haz;
  logic         w_dst_haz;
  logic         w_long_eff_busy;
  logic         w_fire;
  logic         w_long_fire;
  logic         w_wb_err;
  logic         w_ld_err;

  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] cnt;
    cnt = '0;
    for (int i = 0; i < 64; i++) begin
      cnt = cnt + 7'(v[i]);
    end
    return cnt;
  endfunction

  // Integer x0 is hardwired: it never becomes pending and its writebacks
  // are invisible to both pending tracking and error checking.
  assign w_wb_live = wb_valid && (wb_rd_f || (wb_rd != 5'd0));
  assign w_rd_live = writes_rd && (rd_f || (rd != 5'd0));

  always_comb begin
    w_clr_mask = '0;
    if (w_wb_live) begin
      w_clr_mask[{wb_rd_f, wb_rd}] = 1'b1;
    end
  end

  // Hazards are evaluated against the pending set with this cycle's
  // writeback already removed, so a completing producer releases its
  // consumer in the same cycle.
  assign w_pend_eff = r_pending & ~w_clr_mask;

  assign w_src_haz = (uses_rs1 && w_pend_eff[{rs1_f, rs1}]) ||
                     (uses_rs2 && w_pend_eff[{rs2_f, rs2}]) ||
                     (uses_rs3 && w_pend_eff[{rs3_f, rs3}]);
  assign w_dst_haz = writes_rd && w_pend_eff[{rd_f, rd}];

  // A finishing long op frees the unit for a back-to-back long issue.
  assign w_long_eff_busy = long_busy && !long_done;

  assign issue_ready = !w_src_haz && !w_dst_haz && !(is_long && w_long_eff_busy);
  assign w_fire      = issue_valid && issue_ready;
  assign w_long_fire = w_fire && is_long;

  always_comb begin
    w_set_mask = '0;
    if (w_fire && w_rd_live) begin
      w_set_mask[{rd_f, rd}] = 1'b1;
    end
  end

  // Set is OR-ed in after the clear so a same-cycle set wins.
  assign w_pend_nxt = (r_pending & ~w_clr_mask) | w_set_mask;

  // Stray writebacks are flagged only once something has been made pending
  // since reset; writebacks for work discarded by a reset are tolerated.
  assign w_wb_err = w_wb_live && !r_pending[{wb_rd_f, wb_rd}] && r_armed;
  assign w_ld_err = long_done && (r_state == S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_long_fire) w_state_nxt = S_BUSY;
      S_BUSY: if (long_done && !w_long_fire) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
      r_count   <= '0;
      r_stall   <= '0;
      r_error   <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_pending <= w_pend_nxt;
      r_count   <= popcount64(w_pend_nxt);
      if (issue_valid && !issue_ready && (r_stall != C_STALL_MAX)) begin
        r_stall <= r_stall + STALL_W'(1);
      end
      if (w_wb_err || w_ld_err) begin
        r_error <= 1'b1;
      end
      if (|w_set_mask) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign long_busy     = (r_state == S_BUSY);
  assign pending_count = r_count;
  assign stall_cycles  = r_stall;
  assign error         = r_error;

endmodule
`default_nettype wire
